// File: rtl/prsgen8.sv
// 8-bit Galois LFSR pseudo-random bit source, seeded from an input byte at reset release.
// Optional macro PRSGEN8_STATE_OUT_EN adds the state_out[7:0] port.
module prsgen8 #(
    parameter logic [7:0] TAPS     = 8'hB8,
    parameter logic [7:0] ZERO_SUB = 8'h01
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] seed,
`ifdef PRSGEN8_STATE_OUT_EN
    output logic [7:0] state_out,
`endif
    output logic       out
);

    localparam int unsigned W = 8;

    logic [W-1:0] state_q, state_d;
    logic         loaded_q, loaded_d;
    logic         out_q, out_d;

    // Load the seed on the first edge after release, then take Galois steps.
    always_comb begin
        state_d  = state_q;
        loaded_d = loaded_q;
        if (!loaded_q) begin
            state_d  = (seed == W'(0)) ? ZERO_SUB : seed;
            loaded_d = 1'b1;
        end else if (state_q[0]) begin
            state_d = (state_q >> 1) ^ TAPS;
        end else begin
            state_d = state_q >> 1;
        end
        out_d = loaded_d & state_d[0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= '0;
            loaded_q <= 1'b0;
            out_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            loaded_q <= loaded_d;
            out_q    <= out_d;
        end
    end

    assign out = out_q;

`ifdef PRSGEN8_STATE_OUT_EN
    logic [W-1:0] state_out_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_out_q <= '0;
        end else begin
            state_out_q <= loaded_d ? state_d : W'(0);
        end
    end

    assign state_out = state_out_q;
`endif

endmodule

// File: tb/tb_prsgen8.sv
// Scoreboard bench for prsgen8: a reference LFSR model queues expected bits per driven edge.
module tb_prsgen8;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] seed  = 8'h80;
    logic       out;
`ifdef PRSGEN8_STATE_OUT_EN
    logic [7:0] state_out;
`endif

    int errors = 0;
    int checks = 0;

    bit         exp_q[$];
    logic [7:0] exp_s_q[$];
    logic [7:0] m_state;
    logic       m_loaded;

    prsgen8 dut (
        .clk      (clk),
        .reset    (reset),
        .seed     (seed),
`ifdef PRSGEN8_STATE_OUT_EN
        .state_out(state_out),
`endif
        .out      (out)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] galois(input logic [7:0] s);
        return s[0] ? ((s >> 1) ^ 8'hB8) : (s >> 1);
    endfunction

    // Predict the next edge, queue the expectation, and advance one clock.
    task automatic drive_cycle();
        if (!m_loaded) begin
            m_state  = (seed == 8'h00) ? 8'h01 : seed;
            m_loaded = 1'b1;
        end else begin
            m_state = galois(m_state);
        end
        exp_q.push_back(m_state[0]);
        exp_s_q.push_back(m_state);
        @(posedge clk);
        #1;
    endtask

    // Assert reset between edges, hold for n edges, release on a falling edge.
    task automatic apply_reset(input int n, input string name);
        reset    = 1'b0;
        m_state  = 8'h00;
        m_loaded = 1'b0;
        exp_q.delete();
        exp_s_q.delete();
        #1;
        checks++;
        if (out !== 1'b0) begin
            errors++;
            $display("FAIL %s_async_clear: out=%b want 0", name, out);
        end
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out !== 1'b0) begin
                errors++;
                $display("FAIL %s_held[%0d]: out=%b want 0", name, i, out);
            end
`ifdef PRSGEN8_STATE_OUT_EN
            checks++;
            if (state_out !== 8'h00) begin
                errors++;
                $display("FAIL %s_held_state[%0d]: state_out=%h want 00", name, i, state_out);
            end
`endif
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Expect the documented seed-0x80 sequence from the load edge onward.
    task automatic check_ref_seq(input string name);
        bit         r_out [13] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1};
        logic [7:0] r_st  [13] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02,
                                   8'h01, 8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3};
        bit         e;
        logic [7:0] es;
        for (int i = 0; i < 13; i++) begin
            drive_cycle();
            e  = exp_q.pop_front();
            es = exp_s_q.pop_front();
            checks++;
            if (out !== r_out[i]) begin
                errors++;
                $display("FAIL %s_out[%0d]: out=%b want %b", name, i, out, r_out[i]);
            end
`ifdef PRSGEN8_STATE_OUT_EN
            checks++;
            if (state_out !== r_st[i]) begin
                errors++;
                $display("FAIL %s_state[%0d]: state_out=%h want %h", name, i, state_out, r_st[i]);
            end
`endif
        end
    endtask

    task automatic test_reset();
        seed = 8'h80;
        #2;
        apply_reset(2, "reset");
        check_ref_seq("ref_seq");
    endtask

    task automatic test_period();
        logic       obs [511];
        bit         e;
        logic [7:0] es;
        bit         seen [256];
        seed = 8'h80;
        apply_reset(1, "period");
        for (int i = 0; i < 511; i++) begin
            drive_cycle();
            e  = exp_q.pop_front();
            es = exp_s_q.pop_front();
            obs[i] = out;
            checks++;
            if (out !== e) begin
                errors++;
                $display("FAIL period_out[%0d]: out=%b want %b", i, out, e);
            end
`ifdef PRSGEN8_STATE_OUT_EN
            if (i < 255) begin
                checks++;
                if (state_out === 8'h00 || seen[state_out]) begin
                    errors++;
                    $display("FAIL period_distinct[%0d]: state_out=%h repeated or zero", i, state_out);
                end else begin
                    seen[state_out] = 1'b1;
                end
            end
`endif
        end
        for (int i = 0; i < 256; i++) begin
            checks++;
            if (obs[i] !== obs[i + 255]) begin
                errors++;
                $display("FAIL period_repeat[%0d]: out=%b want %b", i + 255, obs[i + 255], obs[i]);
            end
        end
    endtask

    task automatic test_zero_seed();
        bit         e;
        logic [7:0] es;
        int         ones = 0;
        seed = 8'h00;
        apply_reset(2, "zero");
        drive_cycle();
        void'(exp_q.pop_front());
        void'(exp_s_q.pop_front());
        checks++;
        if (out !== 1'b1) begin
            errors++;
            $display("FAIL zero_load_out: out=%b want 1", out);
        end
`ifdef PRSGEN8_STATE_OUT_EN
        checks++;
        if (state_out !== 8'h01) begin
            errors++;
            $display("FAIL zero_load_state: state_out=%h want 01", state_out);
        end
`endif
        drive_cycle();
        void'(exp_q.pop_front());
        void'(exp_s_q.pop_front());
        checks++;
        if (out !== 1'b0) begin
            errors++;
            $display("FAIL zero_step_out: out=%b want 0", out);
        end
`ifdef PRSGEN8_STATE_OUT_EN
        checks++;
        if (state_out !== 8'hB8) begin
            errors++;
            $display("FAIL zero_step_state: state_out=%h want b8", state_out);
        end
`endif
        for (int i = 0; i < 30; i++) begin
            drive_cycle();
            e  = exp_q.pop_front();
            es = exp_s_q.pop_front();
            if (out === 1'b1) ones++;
            checks++;
            if (out !== e) begin
                errors++;
                $display("FAIL zero_run_out[%0d]: out=%b want %b", i, out, e);
            end
        end
        checks++;
        if (ones == 0) begin
            errors++;
            $display("FAIL zero_not_stuck: ones=%0d want >0", ones);
        end
    endtask

    task automatic test_midrun_reset();
        bit         e;
        logic [7:0] es;
        seed = 8'h80;
        apply_reset(1, "mid_pre");
        for (int i = 0; i < 40; i++) begin
            drive_cycle();
            e  = exp_q.pop_front();
            es = exp_s_q.pop_front();
            checks++;
            if (out !== e) begin
                errors++;
                $display("FAIL mid_run_out[%0d]: out=%b want %b", i, out, e);
            end
        end
        // Step on until out is high so the asynchronous clear is observable.
        for (int i = 0; i < 16 && m_state[0] !== 1'b1; i++) begin
            drive_cycle();
            void'(exp_q.pop_front());
            void'(exp_s_q.pop_front());
        end
        checks++;
        if (out !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_high: out=%b want 1", out);
        end
        #2;
        apply_reset(1, "mid");
        check_ref_seq("mid_restart");
    endtask

    task automatic test_seed_change();
        bit         e;
        logic [7:0] es;
        seed = 8'h80;
        apply_reset(1, "seedchg_pre");
        for (int i = 0; i < 25; i++) begin
            if (i == 5) seed = 8'h5A;
            drive_cycle();
            e  = exp_q.pop_front();
            es = exp_s_q.pop_front();
            checks++;
            if (out !== e) begin
                errors++;
                $display("FAIL seedchg_run_out[%0d]: out=%b want %b", i, out, e);
            end
`ifdef PRSGEN8_STATE_OUT_EN
            checks++;
            if (state_out !== es) begin
                errors++;
                $display("FAIL seedchg_run_state[%0d]: state_out=%h want %h", i, state_out, es);
            end
`endif
        end
        apply_reset(1, "seedchg");
        drive_cycle();
        void'(exp_q.pop_front());
        void'(exp_s_q.pop_front());
        checks++;
        if (out !== 1'b0) begin
            errors++;
            $display("FAIL seedchg_load_out: out=%b want 0", out);
        end
`ifdef PRSGEN8_STATE_OUT_EN
        checks++;
        if (state_out !== 8'h5A) begin
            errors++;
            $display("FAIL seedchg_load_state: state_out=%h want 5a", state_out);
        end
`endif
        drive_cycle();
        void'(exp_q.pop_front());
        void'(exp_s_q.pop_front());
        checks++;
        if (out !== 1'b1) begin
            errors++;
            $display("FAIL seedchg_step_out: out=%b want 1", out);
        end
`ifdef PRSGEN8_STATE_OUT_EN
        checks++;
        if (state_out !== 8'h2D) begin
            errors++;
            $display("FAIL seedchg_step_state: state_out=%h want 2d", state_out);
        end
`endif
    endtask

    task automatic test_reset_hold();
        bit         e;
        logic [7:0] es;
        seed = 8'h03;
        apply_reset(20, "hold");
        // A pending load (not a step) must happen on the first edge after release.
        drive_cycle();
        void'(exp_q.pop_front());
        void'(exp_s_q.pop_front());
        checks++;
        if (out !== 1'b1) begin
            errors++;
            $display("FAIL hold_load_out: out=%b want 1", out);
        end
        for (int i = 0; i < 4; i++) begin
            drive_cycle();
            e  = exp_q.pop_front();
            es = exp_s_q.pop_front();
            checks++;
            if (out !== e) begin
                errors++;
                $display("FAIL hold_run_out[%0d]: out=%b want %b", i, out, e);
            end
        end
    endtask

    initial begin
        m_state  = 8'h00;
        m_loaded = 1'b0;
        test_reset();
        test_period();
        test_zero_seed();
        test_midrun_reset();
        test_seed_change();
        test_reset_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
